// File: rtl/inst_mem_pkg.sv
// Shared constants and helpers for the synchronous instruction memory:
// the default NOP encoding, the boot program image and the fetch
// fault rule (misaligned or beyond the last stored word).
package inst_mem_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0

  localparam int BOOT_WORDS = 8;

  // Index 0 is the first word listed.
  localparam logic [0:BOOT_WORDS-1][31:0] BOOT_PROG = {
    32'h0094_0333, 32'h4139_03b3, 32'h00f7_68b3, 32'h017b_4e33,
    32'h00d6_7fb3, 32'h01bd_2f33, 32'h00d6_7fb3, 32'h00f7_68b3
  };

  // Word 'idx' of the reset image: boot program first, 'fill' afterwards.
  function automatic logic [31:0] boot_word(input int idx, input logic [31:0] fill);
    logic [2:0] sel;
    sel = idx[2:0];
    if (idx >= 0 && idx < BOOT_WORDS) begin
      return BOOT_PROG[sel];
    end else begin
      return fill;
    end
  endfunction

  // A pc faults when it is not word aligned or its full word index lies
  // at or beyond depth_words. The pc is zero-extended by the caller so no
  // upper address bit is ever dropped before the comparison.
  function automatic logic pc_fault(input logic [63:0] pc, input int depth_words);
    return (pc[1:0] != 2'b00) || ((pc >> 2) >= 64'(depth_words));
  endfunction

endpackage

// File: rtl/inst_mem_array.sv
// DEPTH_WORDS x 32 storage with one registered read port and one write
// port. A read and a write of the same word in one cycle return the old
// word. Optional macro INST_MEM_INIT_EN: reset loads the boot image.
module inst_mem_array
  import inst_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] NOP_INSTR   = NOP_INSTR_DEFAULT,
  localparam int         AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Registered read, gated write; reset blocks any write in the same cycle.
  // NOTE: non-blocking assignments make the read sample mem_q before this
  // edge's write lands, which is exactly the read-before-write behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
`ifdef INST_MEM_INIT_EN
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= boot_word(i, NOP_INSTR);
      end
`endif
      // NOTE: without the init image the storage is deliberately left
      // unreset, so it can map onto plain RAM and keeps code across reset.
    end else begin
      if (re_i) begin
        rdata_q <= mem_q[raddr_i];
      end
      if (we_i) begin
        mem_q[waddr_i] <= wdata_i;
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_mem_sync.sv
// Synchronous word-organised instruction memory between fetch and decode.
// Request valid/ready in, single-entry response register out (no bubble),
// program write port with out-of-range error flag, fetch fault detection.
// Optional macro INST_MEM_INIT_EN: reset loads the boot program.
module inst_mem_sync
  import inst_mem_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] NOP_INSTR   = NOP_INSTR_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_pc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_instr,
  output logic [ADDR_W-1:0] rsp_pc,
  output logic              rsp_fault,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_wdata,
  output logic              prog_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic              accept;
  logic              req_fault;
  logic              prog_oor;
  logic              arr_re;
  logic              arr_we;
  logic [31:0]       arr_rdata;

  logic              rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0] rsp_pc_q,    rsp_pc_d;
  logic              rsp_fault_q, rsp_fault_d;
  logic              prog_err_q,  prog_err_d;

  // Handshake decode and range checks on the full, untruncated addresses.
  always_comb begin
    req_ready = !rsp_valid_q || rsp_ready;
    accept    = req_valid && req_ready;
    req_fault = pc_fault(64'(req_pc), DEPTH_WORDS);
    prog_oor  = pc_fault(64'(prog_addr) & ~64'h3, DEPTH_WORDS);
    arr_re    = accept && !req_fault;
    arr_we    = prog_we && !prog_oor;
  end

  inst_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .NOP_INSTR   (NOP_INSTR)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .re_i    (arr_re),
    .raddr_i (req_pc[AW+1:2]),
    .rdata_o (arr_rdata),
    .we_i    (arr_we),
    .waddr_i (prog_addr[AW+1:2]),
    .wdata_i (prog_wdata)
  );

  // Next state of the response register: load on accept, drop valid on drain.
  // NOTE: every output gets its hold value first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_pc_d    = rsp_pc_q;
    rsp_fault_d = rsp_fault_q;
    prog_err_d  = prog_we && prog_oor;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_pc_d    = req_pc;
      rsp_fault_d = req_fault;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Response and error registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_pc_q    <= '0;
      rsp_fault_q <= 1'b0;
      prog_err_q  <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_pc_q    <= rsp_pc_d;
      rsp_fault_q <= rsp_fault_d;
      prog_err_q  <= prog_err_d;
    end
  end

  // A faulted fetch never enables the array read, so substitute the NOP here.
  assign rsp_valid = rsp_valid_q;
  assign rsp_pc    = rsp_pc_q;
  assign rsp_fault = rsp_fault_q;
  assign rsp_instr = rsp_fault_q ? NOP_INSTR : arr_rdata;
  assign prog_err  = prog_err_q;

endmodule

// File: tb/tb_inst_mem_sync.sv
// Bench for inst_mem_sync: a word-array reference model checked every
// cycle, plus directed vectors with literal expected values.
module tb_inst_mem_sync;

  localparam int          ADDR_W = 32;
  localparam int          DEPTH  = 64;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic [31:0] boot [8] = '{32'h00940333, 32'h413903b3, 32'h00f768b3, 32'h017b4e33,
                            32'h00d67fb3, 32'h01bd2f33, 32'h00d67fb3, 32'h00f768b3};

  logic              clk;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_pc;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_instr;
  logic [ADDR_W-1:0] rsp_pc;
  logic              rsp_fault;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [31:0]       prog_wdata;
  logic              prog_err;

  int n_checks = 0;
  int n_errors = 0;

  inst_mem_sync #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_pc     (req_pc),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_instr  (rsp_instr),
    .rsp_pc     (rsp_pc),
    .rsp_fault  (rsp_fault),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .prog_err   (prog_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory as an array of words, response as one slot.
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  logic        m_valid, m_fault, m_err;
  logic [31:0] m_pc, m_instr;
  bit          m_instr_known;
  bit          m_live = 0;
  bit          m_f;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 0; m_fault = 0; m_err = 0; m_pc = 0; m_instr = 0;
      m_instr_known = 1; m_live = 1;
`ifdef INST_MEM_INIT_EN
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i]   = (i < 8) ? boot[i] : NOP;
        m_known[i] = 1;
      end
`endif
    end else begin
      if (req_valid && (!m_valid || rsp_ready)) begin
        m_f     = (req_pc % 4 != 0) || (req_pc / 4 >= DEPTH);
        m_valid = 1;
        m_pc    = req_pc;
        m_fault = m_f;
        if (m_f) begin
          m_instr = NOP; m_instr_known = 1;
        end else begin
          m_instr = m_mem[req_pc / 4]; m_instr_known = m_known[req_pc / 4];
        end
      end else if (rsp_ready) begin
        m_valid = 0;
      end
      m_err = prog_we && (prog_addr / 4 >= DEPTH);
      if (prog_we && (prog_addr / 4 < DEPTH)) begin
        m_mem[prog_addr / 4]   = prog_wdata;
        m_known[prog_addr / 4] = 1;
      end
    end
  end

  // Compare DUT with the model mid-cycle, away from the clock edge.
  always @(negedge clk) begin
    if (m_live) begin
      check("m_rsp_valid", rsp_valid, m_valid);
      check("m_rsp_pc",    rsp_pc,    m_pc);
      check("m_rsp_fault", rsp_fault, m_fault);
      check("m_prog_err",  prog_err,  m_err);
      check("m_req_ready", req_ready, !m_valid || rsp_ready);
      if (m_instr_known) check("m_rsp_instr", rsp_instr, m_instr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic prog_write(input logic [31:0] addr, input logic [31:0] data);
    prog_we = 1; prog_addr = addr; prog_wdata = data;
    step();
    prog_we = 0;
  endtask

  initial begin
    reset = 1; req_valid = 0; req_pc = 0; rsp_ready = 1;
    prog_we = 0; prog_addr = 0; prog_wdata = 0;
    step(); step();
    reset = 0;
    check("rst_valid", rsp_valid, 0);
    check("rst_instr", rsp_instr, 0);
    check("rst_pc",    rsp_pc,    0);
    check("rst_fault", rsp_fault, 0);
    check("rst_err",   prog_err,  0);
    check("rst_ready", req_ready, 1);

    // Load the boot program through the program port.
    for (int i = 0; i < 8; i++) prog_write(32'(4 * i), boot[i]);

    // Back-to-back fetches, one response per cycle, 1-cycle latency.
    req_valid = 1;
    for (int i = 0; i < 4; i++) begin
      req_pc = 32'(4 * i);
      step();
      check("seq_instr", rsp_instr, boot[i]);
      check("seq_pc",    rsp_pc,    32'(4 * i));
      check("seq_fault", rsp_fault, 0);
      check("seq_valid", rsp_valid, 1);
    end
    req_valid = 0;
    step();
    check("drain_valid", rsp_valid, 0);
    check("drain_hold",  rsp_instr, boot[3]);

    // Write then fetch; then write and fetch in the same cycle.
    prog_write(32'h10, 32'hDEADBEEF);
    req_valid = 1; req_pc = 32'h10;
    step();
    check("wr_rd", rsp_instr, 32'hDEADBEEF);
    prog_we = 1; prog_addr = 32'h10; prog_wdata = 32'h12345678;
    step();
    check("rbw_old", rsp_instr, 32'hDEADBEEF);
    prog_we = 0;
    step();
    check("rbw_new", rsp_instr, 32'h12345678);

    // Fault boundaries.
    req_pc = 32'h6;
    step();
    check("mis_fault", rsp_fault, 1);
    check("mis_instr", rsp_instr, NOP);
    req_pc = 32'h100;
    step();
    check("oor_fault", rsp_fault, 1);
    check("oor_instr", rsp_instr, NOP);
    req_pc = 32'hFFFF_FFFC;
    step();
    check("wrap_fault", rsp_fault, 1);
    req_valid = 0;
    prog_write(32'hFC, 32'hCAFEF00D);
    req_valid = 1; req_pc = 32'hFC;
    step();
    check("last_fault", rsp_fault, 0);
    check("last_instr", rsp_instr, 32'hCAFEF00D);
    req_valid = 0;
    step();

    // Stall for three cycles, then release.
    rsp_ready = 0; req_valid = 1; req_pc = 32'h8;
    step();
    check("stall_acc", rsp_instr, boot[2]);
    req_pc = 32'hC;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_ready", req_ready, 0);
      check("stall_instr", rsp_instr, boot[2]);
      check("stall_pc",    rsp_pc,    32'h8);
      check("stall_valid", rsp_valid, 1);
    end
    rsp_ready = 1;
    #1;
    check("release_ready", req_ready, 1);
    step();
    check("release_instr", rsp_instr, boot[3]);
    check("release_pc",    rsp_pc,    32'hC);
    req_valid = 0;
    step();

    // Out-of-range program write: one-cycle error, memory untouched.
    prog_write(32'h400, 32'h0BAD0BAD);
    check("perr_hi", prog_err, 1);
    step();
    check("perr_lo", prog_err, 0);
    req_valid = 1; req_pc = 32'h0;
    step();
    check("perr_nowrite", rsp_instr, boot[0]);
    req_valid = 0;
    step();

    // Reset while stalled with an error pending; write during reset ignored.
    rsp_ready = 0; req_valid = 1; req_pc = 32'h4;
    prog_we = 1; prog_addr = 32'h400;
    step();
    check("pre_rst_valid", rsp_valid, 1);
    check("pre_rst_err",   prog_err,  1);
    req_valid = 0;
    reset = 1; prog_we = 1; prog_addr = 32'h14; prog_wdata = 32'h55555555;
    step();
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_err",   prog_err,  0);
    reset = 0; prog_we = 0; rsp_ready = 1;
    req_valid = 1; req_pc = 32'h14;
    step();
    check("rst_wr_ignored", rsp_instr, boot[5]);
`ifndef INST_MEM_INIT_EN
    req_pc = 32'h10;
    step();
    check("retain_after_rst", rsp_instr, 32'h12345678);
`endif
    req_valid = 0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
